// File: rtl/regfile_alu_sequencer_if.sv
// Instruction handshake plus register-file / ALU / write-back control bundle.
// master = sequencer side, slave = instruction source and datapath side.
interface regfile_alu_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [4:0]       rr1;
    logic [4:0]       rr2;
    logic [4:0]       wr;
    logic             reg_we;
    logic [3:0]       alu_op;
    logic [4:0]       shamt;
    logic             wb_sel;
    logic [31:0]      imm_data;
    logic             busy;
    logic             done;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  in_valid, instr,
        output in_ready, rr1, rr2, wr, reg_we, alu_op, shamt, wb_sel,
               imm_data, busy, done, illegal, retired
    );

    modport slave (
        output in_valid, instr,
        input  in_ready, rr1, rr2, wr, reg_we, alu_op, shamt, wb_sel,
               imm_data, busy, done, illegal, retired
    );
endinterface

// File: rtl/regfile_alu_sequencer.sv
// Four-cycle IDLE/DECODE/EXEC/WB sequencer that decodes one MIPS R-type or LUI
// instruction per handshake and drives the register file / ALU / write-back mux.
module regfile_alu_sequencer #(
    parameter int unsigned CNT_W            = 16,
    parameter bit          ZERO_REG_PROTECT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    regfile_alu_sequencer_if.master    bus
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;

    localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [OP_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [OP_W-1:0] ALU_SRL = 4'b1101;
    localparam logic [OP_W-1:0] ALU_SLL = 4'b1110;
    localparam logic [OP_W-1:0] ALU_SRA = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_e;

    state_e              state_q,    state_d;
    logic [REG_W-1:0]    rr1_q,      rr1_d;
    logic [REG_W-1:0]    rr2_q,      rr2_d;
    logic [REG_W-1:0]    wr_q,       wr_d;
    logic                reg_we_q,   reg_we_d;
    logic [OP_W-1:0]     alu_op_q,   alu_op_d;
    logic [REG_W-1:0]    shamt_q,    shamt_d;
    logic                wb_sel_q,   wb_sel_d;
    logic [DATA_W-1:0]   imm_data_q, imm_data_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic                illegal_q,  illegal_d;
    logic [CNT_W-1:0]    retired_q,  retired_d;
    logic                legal_q,    legal_d;
    logic                wen_q,      wen_d;

    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [REG_W-1:0]    f_rs;
    logic [REG_W-1:0]    f_rt;
    logic [REG_W-1:0]    f_rd;
    logic [REG_W-1:0]    f_sh;
    logic [15:0]         f_imm;

    logic [REG_W-1:0]    dec_rr1;
    logic [REG_W-1:0]    dec_rr2;
    logic [REG_W-1:0]    dec_wr;
    logic [OP_W-1:0]     dec_alu;
    logic [REG_W-1:0]    dec_sh;
    logic                dec_wb;
    logic [DATA_W-1:0]   dec_imm;
    logic                dec_legal;
    logic                dec_we;
    logic                accept_c;

    assign opcode = bus.instr[31:26];
    assign f_rs   = bus.instr[25:21];
    assign f_rt   = bus.instr[20:16];
    assign f_rd   = bus.instr[15:11];
    assign f_sh   = bus.instr[10:6];
    assign funct  = bus.instr[5:0];
    assign f_imm  = bus.instr[15:0];

    // Ready is a pure decode of IDLE, gated so it drops the instant reset asserts.
    assign bus.in_ready = rst_n && (state_q == S_IDLE);
    assign accept_c     = bus.in_valid && bus.in_ready;

    // Instruction decode; unsupported encodings keep raw field values and clear dec_legal.
    always_comb begin
        dec_rr1   = f_rs;
        dec_rr2   = f_rt;
        dec_wr    = f_rd;
        dec_alu   = ALU_ADD;
        dec_sh    = '0;
        dec_wb    = 1'b1;
        dec_imm   = {f_imm, 16'h0000};
        dec_legal = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                case (funct)
                    FN_ADD: begin dec_alu = ALU_ADD; dec_legal = 1'b1; end
                    FN_SUB: begin dec_alu = ALU_SUB; dec_legal = 1'b1; end
                    FN_AND: begin dec_alu = ALU_AND; dec_legal = 1'b1; end
                    FN_OR:  begin dec_alu = ALU_OR;  dec_legal = 1'b1; end
                    FN_NOR: begin dec_alu = ALU_NOR; dec_legal = 1'b1; end
                    FN_SLT: begin dec_alu = ALU_SLT; dec_legal = 1'b1; end
                    FN_SLL: begin
                        dec_alu   = ALU_SLL;
                        dec_rr1   = '0;
                        dec_sh    = f_sh;
                        dec_legal = 1'b1;
                    end
                    FN_SRL: begin
                        dec_alu   = ALU_SRL;
                        dec_rr1   = '0;
                        dec_sh    = f_sh;
                        dec_legal = 1'b1;
                    end
                    // The ALU arithmetic-shifts its A operand, so rt moves to port 1.
                    FN_SRA: begin
                        dec_alu   = ALU_SRA;
                        dec_rr1   = f_rt;
                        dec_rr2   = '0;
                        dec_sh    = f_sh;
                        dec_legal = 1'b1;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                dec_wr    = f_rt;
                dec_rr1   = '0;
                dec_rr2   = '0;
                dec_alu   = ALU_ADD;
                dec_wb    = 1'b0;
                dec_legal = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
        dec_we = dec_legal && !(ZERO_REG_PROTECT && (dec_wr == '0));
    end

    // Next-state and next-output logic; pulses default low, datapath fields hold.
    always_comb begin
        state_d    = state_q;
        rr1_d      = rr1_q;
        rr2_d      = rr2_q;
        wr_d       = wr_q;
        alu_op_d   = alu_op_q;
        shamt_d    = shamt_q;
        wb_sel_d   = wb_sel_q;
        imm_data_d = imm_data_q;
        legal_d    = legal_q;
        wen_d      = wen_q;
        retired_d  = retired_q;
        reg_we_d   = 1'b0;
        done_d     = 1'b0;
        illegal_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    rr1_d      = dec_rr1;
                    rr2_d      = dec_rr2;
                    wr_d       = dec_wr;
                    alu_op_d   = dec_alu;
                    shamt_d    = dec_sh;
                    wb_sel_d   = dec_wb;
                    imm_data_d = dec_imm;
                    legal_d    = dec_legal;
                    wen_d      = dec_we;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                reg_we_d = wen_q;
                state_d  = S_WB;
            end
            S_WB: begin
                done_d    = 1'b1;
                illegal_d = !legal_q;
                if (legal_q) begin
                    retired_d = retired_q + CNT_W'(1);
                end
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr1_q      <= '0;
            rr2_q      <= '0;
            wr_q       <= '0;
            reg_we_q   <= 1'b0;
            alu_op_q   <= '0;
            shamt_q    <= '0;
            wb_sel_q   <= 1'b0;
            imm_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            retired_q  <= '0;
            legal_q    <= 1'b0;
            wen_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr1_q      <= rr1_d;
            rr2_q      <= rr2_d;
            wr_q       <= wr_d;
            reg_we_q   <= reg_we_d;
            alu_op_q   <= alu_op_d;
            shamt_q    <= shamt_d;
            wb_sel_q   <= wb_sel_d;
            imm_data_q <= imm_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
            retired_q  <= retired_d;
            legal_q    <= legal_d;
            wen_q      <= wen_d;
        end
    end

    assign bus.rr1      = rr1_q;
    assign bus.rr2      = rr2_q;
    assign bus.wr       = wr_q;
    assign bus.reg_we   = reg_we_q;
    assign bus.alu_op   = alu_op_q;
    assign bus.shamt    = shamt_q;
    assign bus.wb_sel   = wb_sel_q;
    assign bus.imm_data = imm_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.illegal  = illegal_q;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Bench for regfile_alu_sequencer: a register file / ALU driven by the DUT, and an
// instruction-level model predicting per-cycle outputs and architectural register state.
module tb_regfile_alu_sequencer;

    localparam int unsigned CNT_W = 4;
    localparam int          BIG   = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   load_rf = 1'b1;
    always #5 clk = ~clk;

    regfile_alu_sequencer_if #(.CNT_W(CNT_W)) bus ();

    regfile_alu_sequencer #(.CNT_W(CNT_W), .ZERO_REG_PROTECT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Existing datapath: reads latched at negedge, writes committed at posedge.
    logic [31:0] rf [32];
    logic [31:0] rd1, rd2, alu_y;

    always @(negedge clk) begin
        rd1 <= rf[bus.rr1];
        rd2 <= rf[bus.rr2];
    end

    always_comb begin
        alu_y = 32'h0;
        case (bus.alu_op)
            4'b0010: alu_y = rd1 + rd2;
            4'b0110: alu_y = rd1 - rd2;
            4'b0000: alu_y = rd1 & rd2;
            4'b0001: alu_y = rd1 | rd2;
            4'b1100: alu_y = ~(rd1 | rd2);
            4'b0111: alu_y = ($signed(rd1) < $signed(rd2)) ? 32'd1 : 32'd0;
            4'b1110: alu_y = rd2 << bus.shamt;
            4'b1101: alu_y = rd2 >> bus.shamt;
            4'b1111: alu_y = 32'($signed(rd1) >>> bus.shamt);
            default: alu_y = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (load_rf) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i);
        end else if (bus.reg_we) begin
            rf[bus.wr] <= bus.wb_sel ? alu_y : bus.imm_data;
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] word;
        logic        legal;
        logic        lui;
        logic        we;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [4:0]  wr;
        logic [4:0]  sh;
        logic [3:0]  alu;
        logic [31:0] imm;
    } exp_t;

    function automatic exp_t decode(input logic [31:0] w);
        exp_t e;
        e = '0;
        e.word = w;
        if (w[31:26] == 6'h0F) begin
            e.legal = 1'b1; e.lui = 1'b1; e.wr = w[20:16];
            e.alu = 4'b0010; e.imm = {w[15:0], 16'h0};
        end else if (w[31:26] == 6'h00) begin
            e.wr = w[15:11]; e.rr1 = w[25:21]; e.rr2 = w[20:16]; e.legal = 1'b1;
            case (w[5:0])
                6'h20: e.alu = 4'b0010;
                6'h22: e.alu = 4'b0110;
                6'h24: e.alu = 4'b0000;
                6'h25: e.alu = 4'b0001;
                6'h27: e.alu = 4'b1100;
                6'h2A: e.alu = 4'b0111;
                6'h00: begin e.alu = 4'b1110; e.rr1 = 5'd0; e.sh = w[10:6]; end
                6'h02: begin e.alu = 4'b1101; e.rr1 = 5'd0; e.sh = w[10:6]; end
                6'h03: begin e.alu = 4'b1111; e.rr1 = w[20:16]; e.rr2 = 5'd0; e.sh = w[10:6]; end
                default: e.legal = 1'b0;
            endcase
        end
        e.we = e.legal && (e.wr != 5'd0);
        return e;
    endfunction

    // Architectural result of a legal instruction from its source register values.
    function automatic logic [31:0] mips_result(input logic [31:0] w, input logic [31:0] a,
                                                input logic [31:0] b);
        int unsigned s;
        s = 32'(w[10:6]);
        if (w[31:26] == 6'h0F) return {w[15:0], 16'h0};
        case (w[5:0])
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h27: return ~(a | b);
            6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h00: return b << s;
            6'h02: return b >> s;
            6'h03: return 32'($signed(b) >>> s);
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] ref_rf [32];
    int          m_since   = BIG;
    bit          m_have    = 1'b0;
    int          m_retired = 0;
    exp_t        m_cur     = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_since   <= BIG;
            m_have    <= 1'b0;
            m_retired <= 0;
            if (load_rf) for (int i = 0; i < 32; i++) ref_rf[i] <= 32'(i);
        end else begin
            if (m_since == 3) begin
                if (m_cur.we)
                    ref_rf[m_cur.wr] <= mips_result(m_cur.word, ref_rf[m_cur.word[25:21]],
                                                    ref_rf[m_cur.word[20:16]]);
                if (m_cur.legal) m_retired <= (m_retired + 1) % (1 << CNT_W);
            end
            if (bus.in_valid && !(m_since >= 1 && m_since <= 3)) begin
                m_cur   <= decode(bus.instr);
                m_since <= 1;
                m_have  <= 1'b1;
            end else if (m_since < BIG) begin
                m_since <= m_since + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int cyc = 0;
    int we_cyc[$];
    bit run_cmp = 1'b1;

    initial begin : cmp_loop
        bit e_busy;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.reg_we) we_cyc.push_back(cyc);
            if (run_cmp) begin
                e_busy = (m_since >= 1) && (m_since <= 3);
                chk("in_ready", 32'(bus.in_ready), 32'(rst_n && !e_busy));
                chk("busy",     32'(bus.busy),     32'(e_busy));
                chk("reg_we",   32'(bus.reg_we),   32'(m_since == 3 && m_cur.we));
                chk("done",     32'(bus.done),     32'(m_since == 4));
                chk("illegal",  32'(bus.illegal),  32'(m_since == 4 && !m_cur.legal));
                chk("retired",  32'(bus.retired),  32'(m_retired));
                if (!m_have) begin
                    chk("rr1_rst",  32'(bus.rr1), 32'd0);
                    chk("rr2_rst",  32'(bus.rr2), 32'd0);
                    chk("wr_rst",   32'(bus.wr), 32'd0);
                    chk("alu_rst",  32'(bus.alu_op), 32'd0);
                    chk("sh_rst",   32'(bus.shamt), 32'd0);
                    chk("wbs_rst",  32'(bus.wb_sel), 32'd0);
                    chk("imm_rst",  bus.imm_data, 32'd0);
                end else if (m_cur.legal) begin
                    chk("rr1",    32'(bus.rr1), 32'(m_cur.rr1));
                    chk("rr2",    32'(bus.rr2), 32'(m_cur.rr2));
                    chk("wr",     32'(bus.wr), 32'(m_cur.wr));
                    chk("alu_op", 32'(bus.alu_op), 32'(m_cur.alu));
                    chk("wb_sel", 32'(bus.wb_sel), 32'(!m_cur.lui));
                    if (m_cur.lui) chk("imm_data", bus.imm_data, m_cur.imm);
                    else           chk("shamt", 32'(bus.shamt), 32'(m_cur.sh));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] w, input bit keep);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.instr    = w;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!keep) begin
            bus.in_valid = 1'b0;
            bus.instr    = $urandom;
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  op;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k <= 8) w[31:26] = 6'h00;
        case (k)
            0: w[5:0] = 6'h20;
            1: w[5:0] = 6'h22;
            2: w[5:0] = 6'h24;
            3: w[5:0] = 6'h25;
            4: w[5:0] = 6'h27;
            5: w[5:0] = 6'h2A;
            6: w[5:0] = 6'h00;
            7: w[5:0] = 6'h02;
            8: w[5:0] = 6'h03;
            9: w[31:26] = 6'h0F;
            10: begin
                op = 6'($urandom_range(1, 63));
                if (op == 6'h0F) op = 6'h23;
                w[31:26] = op;
            end
            default: w[31:26] = 6'h00;
        endcase
        return w;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.in_valid = 1'b0;
        bus.instr    = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        rst_n   = 1'b1;
        load_rf = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_retired",  32'(bus.retired),  32'd0);

        // Literal pins on the model.
        chk("pin_model_add", mips_result(32'h007F2820, 32'd3, 32'd31), 32'd34);
        chk("pin_model_sra", mips_result(32'h00022083, 32'd0, 32'hF000_0000), 32'hFC00_0000);

        send(32'h007F2820, 1'b0); settle();
        chk("add_rf5",     rf[5], 32'd34);
        chk("add_ref5",    ref_rf[5], 32'd34);
        chk("add_retired", 32'(bus.retired), 32'd1);

        send(32'h00022083, 1'b0); settle();
        chk("sra_rf4", rf[4], 32'd0);
        send(32'h00022080, 1'b0); settle();
        chk("sll_rf4", rf[4], 32'd8);

        send(32'h3C07ABCD, 1'b0); settle();
        chk("lui_rf7", rf[7], 32'hABCD_0000);

        send(32'h8C000000, 1'b0); settle();
        chk("lw_retired", 32'(bus.retired), 32'd4);

        send(32'h00430020, 1'b0); settle();
        chk("rd0_rf0",      rf[0], 32'd0);
        chk("rd0_retired",  32'(bus.retired), 32'd5);

        // Back-to-back: in_valid held across both instructions.
        we_cyc.delete();
        send(32'h00432820, 1'b1);
        send(32'h00853020, 1'b0); settle();
        chk("b2b_we_count", 32'(we_cyc.size()), 32'd2);
        if (we_cyc.size() == 2) chk("b2b_we_gap", 32'(we_cyc[1] - we_cyc[0]), 32'd4);
        chk("b2b_rf5", rf[5], 32'd5);
        chk("b2b_rf6", rf[6], 32'd13);

        // Reset asserted during EXEC discards the instruction.
        send(32'h00434820, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_exec_reg_we",   32'(bus.reg_we),   32'd0);
        chk("rst_exec_busy",     32'(bus.busy),     32'd0);
        chk("rst_exec_done",     32'(bus.done),     32'd0);
        chk("rst_exec_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_retired",  32'(bus.retired),  32'd0);
        settle();
        chk("post_rst_rf9", rf[9], 32'd9);

        // Randomized traffic; retired wraps several times at CNT_W=4.
        for (int i = 0; i < 300; i++) begin
            bit keep;
            keep = ($urandom_range(0, 1) == 1);
            send(rand_instr(), keep);
            if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
        settle();
        for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), rf[i], ref_rf[i]);

        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
